uart_tx_feeder: RTL and testbench

//   Byte FIFO and load sequencer directly upstream of the uart transmitter.

---
 rtl/uart_tx_feeder.sv | 155 +++++++++++++++
 tb/tb_uart_tx_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus load sequencer feeding the uart transmitter; one byte per frame,
// paced by tx_empty. Everything runs on txclk.
module uart_tx_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              ld_tx_data,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    input  logic              tx_empty
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WB_LAST  = 4'd15;

    state_t              state_q, state_d;
    logic [3:0]          wb_cnt_q, wb_cnt_d;
    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_enable_q;
    logic                full_w;
    logic                pop;
    logic                push;
    logic                ld;

    assign full_w = (count_q == FULL_CNT);

    // Sequencer; pop is raised only on the IDLE->LOAD transition and never during flush.
    always_comb begin
        state_d  = state_q;
        wb_cnt_d = wb_cnt_q;
        pop      = 1'b0;
        ld       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_enable_q && tx_empty && (count_q != '0) && !flush) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld       = 1'b1;
                wb_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_empty) begin
                    state_d = WAIT_DONE;
                end else if (wb_cnt_q == WB_LAST) begin
                    state_d = IDLE;
                end else begin
                    wb_cnt_d = wb_cnt_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (tx_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a write in the cycle a byte is popped.
    always_comb begin
        push       = wr_en && !flush && (!full_w || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
        end
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (wr_en && full_w && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wb_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_cnt_q    <= wb_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= enable;
        end
    end

    always_ff @(posedge txclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full       = full_w;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE);
    assign ld_tx_data = ld;
    assign tx_data    = tx_data_q;
    assign tx_enable  = tx_enable_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus queues expected loads, a monitor
// pops them on each ld_tx_data pulse; a small uart model drives tx_empty.
module tb_uart_tx_feeder;

    logic       txclk    = 1'b0;
    logic       reset    = 1'b0;
    logic       enable   = 1'b0;
    logic       wr_en    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       flush    = 1'b0;
    logic       tx_empty = 1'b1;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       busy;
    logic       ld_tx_data;
    logic [7:0] tx_data;
    logic       tx_enable;

    uart_tx_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
        .txclk      (txclk),
        .reset      (reset),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .busy       (busy),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_empty   (tx_empty)
    );

    always #5 txclk = ~txclk;

    int cyc = 0;
    always @(posedge txclk) cyc <= cyc + 1;

    // kind: 0 no latency check, 1 from write cycle, 2 from tx_empty rise, 3 from previous load
    typedef struct {
        logic [7:0] data;
        int         kind;
        int         ref_cyc;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push_exp(input logic [7:0] d, input int kind, input int ref_cyc, input int lat);
        exp_t e;
        e.data = d; e.kind = kind; e.ref_cyc = ref_cyc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // uart model: frame of frame_len cycles after a load; mode 1 ignores loads
    int uart_mode = 0;
    int frame_len = 10;
    int remain    = 0;
    int last_rise = 0;
    always @(negedge txclk) begin
        if (!reset) begin
            tx_empty = 1'b1;
            remain   = 0;
        end else if (ld_tx_data && uart_mode == 0) begin
            tx_empty = 1'b0;
            remain   = frame_len;
        end else if (remain > 0) begin
            remain--;
            if (remain == 0) begin
                tx_empty  = 1'b1;
                last_rise = cyc;
            end
        end
    end

    logic prev_ld     = 1'b0;
    int   last_ld_cyc = 0;
    int   n_ld        = 0;
    exp_t mon_e;
    always @(negedge txclk) begin
        if (ld_tx_data) begin
            n_ld++;
            check("ld_single_pulse", 32'(prev_ld), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_load: got tx_data 0x%0h, required no load", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(mon_e.data));
                case (mon_e.kind)
                    1: check("lat_from_write", 32'(cyc - mon_e.ref_cyc), 32'(mon_e.lat));
                    2: check("lat_from_empty_rise", 32'(cyc - last_rise), 32'(mon_e.lat));
                    3: check("lat_from_prev_load", 32'(cyc - last_ld_cyc), 32'(mon_e.lat));
                    default: ;
                endcase
            end
            last_ld_cyc = cyc;
        end
        prev_ld = ld_tx_data;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge txclk);
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge txclk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drained(input int budget, input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < budget) begin
            @(negedge txclk);
            t++;
        end
        check(name, ((exp_q.size() == 0) && !busy) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int snap;
        int t;
        // reset state, enable already high to show tx_enable is held low
        enable = 1'b1;
        tick(3);
        check("rst_ld", 32'(ld_tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_enable", 32'(tx_enable), 32'd0);
        reset = 1'b1;
        tick(3);
        check("tx_enable_follow", 32'(tx_enable), 32'd1);

        // 1: single byte, load in the 3rd cycle counting the write cycle as the 1st
        push_exp(8'hA5, 1, cyc, 2);
        write(8'hA5);
        wait_drained(100, "t1_drain");
        check("t1_count", 32'(count), 32'd0);

        // 2: back-to-back bytes, each later load 2 cycles after tx_empty rises
        push_exp(8'h01, 1, cyc, 2);
        write(8'h01);
        push_exp(8'h02, 2, 0, 2);
        write(8'h02);
        push_exp(8'h03, 2, 0, 2);
        write(8'h03);
        wait_drained(200, "t2_drain");

        // 3: fill while disabled, 17th write dropped
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            push_exp(8'h10 + 8'(i), 0, 0, 0);
            write(8'h10 + 8'(i));
        end
        write(8'hEE);
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd1);
        enable = 1'b1;
        wait_drained(800, "t3_drain");
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEF;
        tick(1);
        flush   = 1'b0;
        wr_en   = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        tick(5);

        // 4: full FIFO, write lands in the pop cycle
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            push_exp(8'h20 + 8'(i), 0, 0, 0);
            write(8'h20 + 8'(i));
        end
        check("t4_full_before", 32'(full), 32'd1);
        check("t4_overflow_before", 32'(overflow), 32'd0);
        enable = 1'b1;
        tick(1);
        push_exp(8'h77, 0, 0, 0);
        write(8'h77);
        check("t4_count_pop_push", 32'(count), 32'd16);
        check("t4_overflow_after", 32'(overflow), 32'd0);
        wait_drained(900, "t4_drain");

        // 5: uart ignores loads; retry after 16 WAIT_BUSY cycles + IDLE + LOAD
        uart_mode = 1;
        enable = 1'b0;
        tick(2);
        push_exp(8'h5A, 0, 0, 0);
        write(8'h5A);
        push_exp(8'h6B, 3, 0, 18);
        write(8'h6B);
        enable = 1'b1;
        wait_drained(200, "t5_drain");
        check("t5_count", 32'(count), 32'd0);
        uart_mode = 0;

        // 6: reset during WAIT_DONE with 4 bytes queued
        enable = 1'b0;
        tick(2);
        push_exp(8'h81, 0, 0, 0);
        for (int i = 1; i <= 5; i++) write(8'h80 + 8'(i));
        enable = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge txclk);
            t++;
        end
        tick(4);
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_count_pre", 32'(count), 32'd4);
        snap = n_ld;
        reset = 1'b0;
        #1;
        check("t6_rst_ld", 32'(ld_tx_data), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_tx_data", 32'(tx_data), 32'h00);
        check("t6_rst_tx_enable", 32'(tx_enable), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(20);
        check("t6_no_load_after_release", 32'(n_ld), 32'(snap));
        push_exp(8'h99, 1, cyc, 2);
        write(8'h99);
        wait_drained(100, "t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
